// File: rtl/hsclk_cycle_ctrl_if.sv
// rtl/hsclk_cycle_ctrl_if.sv - CPU pin, BBC bus and register bundle for hsclk_cycle_ctrl
interface hsclk_cycle_ctrl_if;
    logic        bbc_phi0;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_bank;
    logic        cpu_vda;
    logic        cpu_vpa;
    logic        cpu_rnw;
    logic [7:0]  cpu_wdata;
    logic        cpu_phi2;
    logic        ram_sel;
    logic [2:0]  ram_bank;
    logic        host_cyc;
    logic [1:0]  bbc_a15_14;
    logic        bbc_rnw;
    logic [7:0]  reg_rdata;
    logic        reg_oe;
    logic [7:0]  map_q;

    modport master (
        output bbc_phi0, cpu_addr, cpu_bank, cpu_vda, cpu_vpa, cpu_rnw, cpu_wdata,
        input  cpu_phi2, ram_sel, ram_bank, host_cyc, bbc_a15_14, bbc_rnw,
               reg_rdata, reg_oe, map_q
    );

    modport slave (
        input  bbc_phi0, cpu_addr, cpu_bank, cpu_vda, cpu_vpa, cpu_rnw, cpu_wdata,
        output cpu_phi2, ram_sel, ram_bank, host_cyc, bbc_a15_14, bbc_rnw,
               reg_rdata, reg_oe, map_q
    );
endinterface

// File: rtl/hsclk_cycle_ctrl.sv
// rtl/hsclk_cycle_ctrl.sv - 65816 cycle generator and memory mapper clocked from hsclk
module hsclk_cycle_ctrl #(
    parameter int          HS_DIV        = 4,
    parameter int          SYNC_STAGES   = 2,
    parameter int          LORAM_PAGES   = 32,
    parameter logic [15:0] ROM_SLOT_MASK = 16'h8000,
    parameter logic [15:0] MOS_REMAP_TOP = 16'hFBFF
) (
    input  logic               hsclk,
    input  logic               reset,
    hsclk_cycle_ctrl_if.slave  bus
);
    localparam int HALF = HS_DIV / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int SW   = SYNC_STAGES + 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(HALF - 1);
    localparam logic [16:0]   LORAM_TOP = 17'(LORAM_PAGES * 256);

    localparam logic [1:0] FPH1  = 2'd0;
    localparam logic [1:0] FPH2  = 2'd1;
    localparam logic [1:0] HWAIT = 2'd2;
    localparam logic [1:0] HPH2  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] phi0_sync;
    logic          phi2_q;
    logic          ram_sel_q;
    logic [2:0]    ram_bank_q;
    logic          host_q;
    logic [1:0]    a15_14_q;
    logic          bbc_rnw_q;
    logic          reg_oe_q;
    logic [7:0]    map_r;
    logic [3:0]    pagereg_q;
    logic          cyc_reg_wr;
    logic          cyc_reg_rd;
    logic          cyc_pg_wr;

    // Extra flop past the synchroniser gives the edge history, so detection lands SYNC_STAGES after the raw edge
    always_ff @(posedge hsclk) begin
        if (reset) phi0_sync <= '0;
        else       phi0_sync <= {phi0_sync[SW-2:0], bus.bbc_phi0};
    end

    logic phi0_rise, phi0_fall;
    assign phi0_rise =  phi0_sync[SW-2] & ~phi0_sync[SW-1];
    assign phi0_fall = ~phi0_sync[SW-2] &  phi0_sync[SW-1];

    logic valid, bank_lo, is_himem, is_reg, ram_remap, rom_win, mos_win, remap;
    logic dec_host, dec_fast, dec_ram;
    assign valid     = bus.cpu_vda | bus.cpu_vpa;
    assign bank_lo   = ~bus.cpu_bank[7];
    assign is_himem  = bus.cpu_bank[7:6] == 2'b11;
    assign is_reg    = (bus.cpu_bank[7:6] == 2'b10) && (bus.cpu_addr[1:0] == 2'b11);
    assign ram_remap = bank_lo & map_r[4] & ({1'b0, bus.cpu_addr} < LORAM_TOP);
    assign rom_win   = (bus.cpu_addr[15:14] == 2'b10) & ROM_SLOT_MASK[pagereg_q];
    assign mos_win   = (bus.cpu_addr >= 16'hC000) && (bus.cpu_addr <= MOS_REMAP_TOP);
    assign remap     = ram_remap | (bank_lo & map_r[5] & (rom_win | mos_win));
    assign dec_host  = valid & bank_lo & ~remap;
    assign dec_ram   = valid & (is_himem | remap);
    // Internal cycles have no bus target, so they only need the host clock when fast mode is off
    assign dec_fast  = map_r[3] & (~valid | is_himem | is_reg | remap);

    logic sample, end_phi2;
    assign sample   = (state == FPH1) && (cnt == CNT_LAST);
    assign end_phi2 = ((state == FPH2) && (cnt == CNT_LAST)) || ((state == HPH2) && phi0_fall);

    always_ff @(posedge hsclk) begin
        if (reset) begin
            state      <= FPH1;
            cnt        <= '0;
            phi2_q     <= 1'b0;
            reg_oe_q   <= 1'b0;
            ram_sel_q  <= 1'b0;
            ram_bank_q <= 3'b000;
            host_q     <= 1'b0;
            a15_14_q   <= 2'b00;
            bbc_rnw_q  <= 1'b1;
            cyc_reg_wr <= 1'b0;
            cyc_reg_rd <= 1'b0;
            cyc_pg_wr  <= 1'b0;
        end else begin
            case (state)
                FPH1: begin
                    if (sample) begin
                        cnt        <= '0;
                        ram_sel_q  <= dec_ram;
                        ram_bank_q <= remap ? 3'b110 : bus.cpu_bank[2:0];
                        host_q     <= dec_host;
                        a15_14_q   <= dec_host ? bus.cpu_addr[15:14] : 2'b10;
                        bbc_rnw_q  <= ~dec_host | bus.cpu_rnw | map_r[6];
                        cyc_reg_wr <= valid & is_reg & ~bus.cpu_rnw;
                        cyc_reg_rd <= valid & is_reg &  bus.cpu_rnw;
                        cyc_pg_wr  <= valid & bank_lo & ~bus.cpu_rnw & (bus.cpu_addr == 16'hFE30);
                        if (dec_fast) begin
                            state    <= FPH2;
                            phi2_q   <= 1'b1;
                            reg_oe_q <= valid & is_reg & bus.cpu_rnw;
                        end else begin
                            state    <= HWAIT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FPH2: begin
                    if (cnt == CNT_LAST) begin
                        state    <= FPH1;
                        cnt      <= '0;
                        phi2_q   <= 1'b0;
                        reg_oe_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HWAIT: begin
                    // Only a fresh rising edge starts phase 2; a phase already in progress is skipped
                    if (phi0_rise) begin
                        state    <= HPH2;
                        phi2_q   <= 1'b1;
                        reg_oe_q <= cyc_reg_rd;
                    end
                end
                default: begin
                    if (phi0_fall) begin
                        state    <= FPH1;
                        cnt      <= '0;
                        phi2_q   <= 1'b0;
                        reg_oe_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge hsclk) begin
        if (reset) begin
            map_r     <= 8'h00;
            pagereg_q <= 4'h0;
        end else if (end_phi2) begin
            if (cyc_reg_wr) map_r     <= bus.cpu_wdata;
            if (cyc_pg_wr)  pagereg_q <= bus.cpu_wdata[3:0];
        end
    end

    logic unused_bank_bits;
    assign unused_bank_bits = ^bus.cpu_bank[5:3];

    assign bus.cpu_phi2   = phi2_q;
    assign bus.ram_sel    = ram_sel_q;
    assign bus.ram_bank   = ram_bank_q;
    assign bus.host_cyc   = host_q;
    assign bus.bbc_a15_14 = a15_14_q;
    assign bus.bbc_rnw    = bbc_rnw_q;
    assign bus.reg_rdata  = map_r;
    assign bus.reg_oe     = reg_oe_q;
    assign bus.map_q      = map_r;
endmodule
